// File: rtl/pill_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pill_pkg
// Brief    : Shared widths and FSM encoding for the pill schedule controller.
// Revision : 1.0 - initial release
// ============================================================================
package pill_pkg;

    localparam int DUR_W     = 4;
    localparam int ID_W      = 4;
    localparam int NUM_PILLS = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_SET_ID = 3'd0;
    localparam state_t ST_SET_P1 = 3'd1;
    localparam state_t ST_SET_P2 = 3'd2;
    localparam state_t ST_SET_P3 = 3'd3;
    localparam state_t ST_RUN    = 3'd4;

endpackage
`default_nettype wire

// File: rtl/key_pulse.sv
`default_nettype none
// ============================================================================
// Module   : key_pulse
// Brief    : Two-flop synchronizer plus falling-edge detector for a raw
//            active-low push-button; emits one pulse per press.
// Revision : 1.0 - initial release
// ============================================================================
module key_pulse (
    input  logic clk,
    input  logic resetn,
    input  logic key_n,
    output logic pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync2_d;

    // Flops reset high so a button held through reset does not register as a press.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_sync2_d <= 1'b1;
        end else begin
            r_sync1   <= key_n;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
        end
    end

    assign pulse = r_sync2_d & ~r_sync2;

endmodule
`default_nettype wire

// File: rtl/pill_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pill_schedule_ctrl
// Brief    : Programs a patient ID and three pill intervals from switches, then
//            runs three countdown timers driving dispense pulses and alarms.
// Revision : 1.0 - initial release
// ============================================================================
module pill_schedule_ctrl
    import pill_pkg::*;
#(
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [DUR_W-1:0]           sw_value,
    input  logic                       key_next_n,
    input  logic                       key_prog_n,
    output logic [ID_W-1:0]            patientID,
    output logic [NUM_PILLS*DUR_W-1:0] pill12And3Duration,
    output logic [NUM_PILLS-1:0]       dispense_pulse,
    output logic [NUM_PILLS-1:0]       alarm_led,
    output logic                       running
);

    localparam int                c_ps_w     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [c_ps_w-1:0] c_tick_max = c_ps_w'(TICK_CYCLES - 1);

    logic                 w_nxt;
    logic                 w_prg;
    state_t               r_state;
    logic [ID_W-1:0]      r_patient_id;
    logic [DUR_W-1:0]     r_dur       [NUM_PILLS];
    logic [DUR_W-1:0]     r_rem       [NUM_PILLS];
    logic [DUR_W-1:0]     w_entry_dur [NUM_PILLS];
    logic [c_ps_w-1:0]    r_prescaler;
    logic [NUM_PILLS-1:0] r_pulse;
    logic [NUM_PILLS-1:0] r_alarm;
    logic                 r_running;
    logic [NUM_PILLS-1:0] w_fire;
    logic                 w_in_run;
    logic                 w_stay_run;
    logic                 w_enter_run;
    logic                 w_tick;
    logic                 w_ack;

    key_pulse u_key_next (
        .clk    (clk),
        .resetn (resetn),
        .key_n  (key_next_n),
        .pulse  (w_nxt)
    );

    key_pulse u_key_prog (
        .clk    (clk),
        .resetn (resetn),
        .key_n  (key_prog_n),
        .pulse  (w_prg)
    );

    // prg takes priority over every other RUN-state action.
    assign w_in_run    = (r_state == ST_RUN);
    assign w_stay_run  = w_in_run & ~w_prg;
    assign w_enter_run = (r_state == ST_SET_P3) & w_nxt;
    assign w_tick      = w_stay_run & (r_prescaler == c_tick_max);
    assign w_ack       = w_stay_run & w_nxt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= ST_SET_ID;
            r_patient_id <= '0;
            for (int i = 0; i < NUM_PILLS; i++) begin
                r_dur[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_SET_ID: if (w_nxt) begin
                    r_patient_id <= sw_value;
                    r_state      <= ST_SET_P1;
                end
                ST_SET_P1: if (w_nxt) begin
                    r_dur[0] <= sw_value;
                    r_state  <= ST_SET_P2;
                end
                ST_SET_P2: if (w_nxt) begin
                    r_dur[1] <= sw_value;
                    r_state  <= ST_SET_P3;
                end
                ST_SET_P3: if (w_nxt) begin
                    r_dur[2] <= sw_value;
                    r_state  <= ST_RUN;
                end
                ST_RUN: if (w_prg) begin
                    r_state <= ST_SET_ID;
                end
                default: r_state <= ST_SET_ID;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_prescaler <= '0;
        end else if (w_stay_run) begin
            r_prescaler <= (r_prescaler == c_tick_max) ? '0 : r_prescaler + c_ps_w'(1);
        end else begin
            r_prescaler <= '0;
        end
    end

    for (genvar gi = 0; gi < NUM_PILLS; gi++) begin : g_pill
        // The last interval is captured on the same edge that enters RUN.
        if (gi == NUM_PILLS - 1) begin : g_last
            assign w_entry_dur[gi] = sw_value;
        end else begin : g_held
            assign w_entry_dur[gi] = r_dur[gi];
        end

        assign w_fire[gi] = w_tick & (r_dur[gi] != '0) & (r_rem[gi] == DUR_W'(1));

        always_ff @(posedge clk) begin
            if (!resetn) begin
                r_rem[gi] <= '0;
            end else if (w_enter_run) begin
                r_rem[gi] <= w_entry_dur[gi];
            end else if (w_tick && (r_dur[gi] != '0)) begin
                r_rem[gi] <= (r_rem[gi] == DUR_W'(1)) ? r_dur[gi] : r_rem[gi] - DUR_W'(1);
            end
        end
    end

    // On an acknowledge, a pill firing on the same edge keeps its alarm set.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pulse   <= '0;
            r_alarm   <= '0;
            r_running <= 1'b0;
        end else begin
            r_pulse   <= w_fire;
            r_running <= w_enter_run | w_stay_run;
            if (w_in_run && w_prg) begin
                r_alarm <= '0;
            end else if (w_ack) begin
                r_alarm <= w_fire;
            end else begin
                r_alarm <= r_alarm | w_fire;
            end
        end
    end

    assign patientID          = r_patient_id;
    assign pill12And3Duration = {r_dur[0], r_dur[1], r_dur[2]};
    assign dispense_pulse     = r_pulse;
    assign alarm_led          = r_alarm;
    assign running            = r_running;

endmodule
`default_nettype wire

// File: tb/tb_pill_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pill_schedule_ctrl
// Brief    : Directed self-checking bench for pill_schedule_ctrl (TICK_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pill_schedule_ctrl;

    localparam int TICK = 4;

    logic        clk;
    logic        resetn;
    logic [3:0]  sw_value;
    logic        key_next_n;
    logic        key_prog_n;
    logic [3:0]  patientID;
    logic [11:0] pill12And3Duration;
    logic [2:0]  dispense_pulse;
    logic [2:0]  alarm_led;
    logic        running;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [2:0]  exp_pulse;
    logic [2:0]  exp_alarm;

    pill_schedule_ctrl #(.TICK_CYCLES(TICK)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .sw_value           (sw_value),
        .key_next_n         (key_next_n),
        .key_prog_n         (key_prog_n),
        .patientID          (patientID),
        .pill12And3Duration (pill12And3Duration),
        .dispense_pulse     (dispense_pulse),
        .alarm_led          (alarm_led),
        .running            (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] v);
        @(negedge clk);
        sw_value   = v;
        key_next_n = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        key_next_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    // Leaves key_next_n low; the caller releases it. "k = 0" is the entry edge.
    task automatic enter_run(input logic [3:0] v);
        @(negedge clk);
        sw_value   = v;
        key_next_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("pre_entry_running", 16'(running), 16'h0);
        @(posedge clk);
        #1 check("entry_running", 16'(running), 16'h1);
    endtask

    initial begin
        resetn     = 1'b0;
        key_next_n = 1'b1;
        key_prog_n = 1'b1;
        sw_value   = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_id",      16'(patientID),          16'h0);
        check("rst_dur",     16'(pill12And3Duration), 16'h0);
        check("rst_pulse",   16'(dispense_pulse),     16'h0);
        check("rst_alarm",   16'(alarm_led),          16'h0);
        check("rst_running", 16'(running),            16'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Program ID 7, durations 2,3,0
        press(4'd7);
        check("prog_id", 16'(patientID), 16'h7);
        press(4'd2);
        press(4'd3);
        check("prog_dur_p3",     16'(pill12And3Duration), 16'h230);
        check("prog_running_p3", 16'(running),            16'h0);
        enter_run(4'd0);
        check("run_dur", 16'(pill12And3Duration), 16'h230);
        check("run_id",  16'(patientID),          16'h7);

        // Ticks act on edges 4,8,..; pill1 fires on multiples of 8, pill2 of 12.
        // Acks land on edge 32 (coincident with pill1) and edge 44.
        exp_alarm = 3'b000;
        for (int k = 1; k <= 48; k++) begin
            @(posedge clk);
            #1;
            exp_pulse = {1'b0, (k % 12) == 0, (k % 8) == 0};
            if (k == 32 || k == 44) exp_alarm = exp_pulse;
            else                    exp_alarm = exp_alarm | exp_pulse;
            check($sformatf("run1_pulse_k%0d", k), 16'(dispense_pulse), 16'(exp_pulse));
            check($sformatf("run1_alarm_k%0d", k), 16'(alarm_led),      16'(exp_alarm));
            if (k == 10) key_next_n = 1'b1;
            if (k == 29) key_next_n = 1'b0;
            if (k == 39) key_next_n = 1'b1;
            if (k == 41) key_next_n = 1'b0;
            if (k == 46) key_next_n = 1'b1;
        end

        // prg and nxt together: prg wins, nothing captured
        sw_value   = 4'hF;
        key_prog_n = 1'b0;
        key_next_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("prg_pending_running", 16'(running), 16'h1);
        @(posedge clk);
        #1;
        check("prg_running", 16'(running),            16'h0);
        check("prg_alarm",   16'(alarm_led),          16'h0);
        check("prg_pulse",   16'(dispense_pulse),     16'h0);
        check("prg_dur",     16'(pill12And3Duration), 16'h230);
        check("prg_id",      16'(patientID),          16'h7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        key_prog_n = 1'b1;
        key_next_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("prg_id_hold", 16'(patientID), 16'h7);

        // Reprogram all durations to 1: every tick fires all pills
        press(4'd9);
        check("prog2_id", 16'(patientID), 16'h9);
        press(4'd1);
        press(4'd1);
        check("prog2_dur_p3", 16'(pill12And3Duration), 16'h110);
        enter_run(4'd1);
        check("run2_dur", 16'(pill12And3Duration), 16'h111);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            exp_pulse = ((k % TICK) == 0) ? 3'b111 : 3'b000;
            check($sformatf("run2_pulse_k%0d", k), 16'(dispense_pulse), 16'(exp_pulse));
            if (k == 10) key_next_n = 1'b1;
        end
        check("run2_alarm", 16'(alarm_led), 16'h7);

        key_prog_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("prg2_running", 16'(running),   16'h0);
        check("prg2_alarm",   16'(alarm_led), 16'h0);
        @(negedge clk);
        key_prog_n = 1'b1;
        repeat (4) @(posedge clk);

        // Durations 2,3,1: counts restart from full durations
        press(4'd7);
        press(4'd2);
        press(4'd3);
        enter_run(4'd1);
        check("run3_dur", 16'(pill12And3Duration), 16'h231);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            exp_pulse = {(k % 4) == 0, (k % 12) == 0, (k % 8) == 0};
            check($sformatf("run3_pulse_k%0d", k), 16'(dispense_pulse), 16'(exp_pulse));
        end
        check("run3_alarm", 16'(alarm_led), 16'h5);
        key_next_n = 1'b1;

        // Synchronous reset mid-RUN
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_id",      16'(patientID),          16'h0);
        check("mid_rst_dur",     16'(pill12And3Duration), 16'h0);
        check("mid_rst_pulse",   16'(dispense_pulse),     16'h0);
        check("mid_rst_alarm",   16'(alarm_led),          16'h0);
        check("mid_rst_running", 16'(running),            16'h0);
        @(negedge clk);
        resetn = 1'b1;
        press(4'd5);
        check("post_rst_id",      16'(patientID),          16'h5);
        check("post_rst_dur",     16'(pill12And3Duration), 16'h0);
        check("post_rst_running", 16'(running),            16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pill_schedule_ctrl.md
Name: pill_schedule_ctrl

Overview:
- Upstream producer for the LCD display stage.
- Operator enters a patient ID and three 4-bit pill intervals from switches, confirming each with a push-button.
- The block then runs three independent countdown timers that fire dispense pulses and latched alarm LEDs.
- Registered patientID and pill12And3Duration outputs drive the LCD top directly.

Parameters:
- TICK_CYCLES, 50_000_000, clk cycles per time unit (1 s at 50 MHz); the bench uses 4.

Ports:
- clk  input  1  system clock (50 MHz)
- resetn  input  1  synchronous active-low reset
- sw_value  input  4  switch value captured on confirm
- key_next_n  input  1  raw active-low button: confirm field / acknowledge alarms
- key_prog_n  input  1  raw active-low button: return to programming
- patientID  output  4  registered patient ID to LCD
- pill12And3Duration  output  12  {pill1[11:8], pill2[7:4], pill3[3:0]} intervals, to LCD
- dispense_pulse  output  3  one-cycle pulse per pill (bit0 = pill1)
- alarm_led  output  3  latched per-pill alarm
- running  output  1  high in RUN state

Behaviour:
- Reset (resetn low at a clk edge) clears every register:
  - all outputs 0, state SET_ID, prescaler 0, remaining counters 0, synchronizer flops 1.
  - Applies identically mid-RUN.
- Buttons: each passes a 2-FF synchronizer, then a falling-edge detector giving a 1-cycle pulse (nxt, prg).
  - Pulse is high during the 3rd clk edge after the pin goes low.
  - Holding the button produces exactly one pulse.
- FSM states: SET_ID -> SET_P1 -> SET_P2 -> SET_P3 -> RUN.
  - In a SET_* state, nxt writes sw_value into that state's field (patientID, pill1, pill2, pill3) and advances on the same edge.
  - prg in SET_* states: ignored.
- SET_P3 -> RUN edge:
  - remaining_i loads dur_i (pill3 uses the just-captured sw_value).
  - prescaler clears; running rises.
- RUN prescaler:
  - counts 0..TICK_CYCLES-1 and wraps.
  - tick is high for one cycle when prescaler == TICK_CYCLES-1.
  - First tick falls exactly TICK_CYCLES cycles after entry.
- RUN, per pill i, on tick:
  - dur_i == 0: pill disabled, never fires.
  - remaining_i == 1: dispense_pulse[i] high the cycle after tick; alarm_led[i] set; remaining_i reloads dur_i.
  - otherwise: remaining_i decrements.
  - Net period: dur_i ticks. dur_i = 1 fires on every tick.
- RUN, nxt: clears all alarm_led bits.
  - A set and a clear on the same edge: set wins for that bit.
- RUN, prg: go to SET_ID.
  - Clear alarm_led, dispense_pulse, running and the prescaler.
  - Keep patientID and durations so the LCD shows the old values until overwritten.
  - prg and nxt on the same cycle: prg wins.
- Outputs are all registered; dispense_pulse is never high outside RUN.
- Widths:
  - remaining_i is 4 bits, unsigned, with no wrap (reload at 1, so it never reaches 0 when enabled).
  - prescaler width is $clog2(TICK_CYCLES).

Decomposition:
- Package pill_pkg holds:
  - state enum (SET_ID, SET_P1, SET_P2, SET_P3, RUN)
  - DUR_W = 4, ID_W = 4, NUM_PILLS = 3
- Sub-module key_pulse (2-FF sync + falling-edge detect, resetn synchronous), instantiated twice.
- Prescaler and countdowns are inline, with one generate loop over the pills.

Test Plan:
- Reset mid-RUN with alarm_led = 3'b101 → next edge: all outputs 0, state SET_ID, running 0.
- Programming: press next four times with sw_value = 7, 2, 3, 0 → patientID = 7, pill12And3Duration = 12'h230, running = 1 after the 4th press; each key held 10 cycles gives exactly one advance.
- Timing, TICK_CYCLES = 4, durations 2,3,0:
  - pill1 pulses at cycles 9, 17, 25, counted from RUN entry at cycle 0.
  - pill2 pulses at cycles 13, 25.
  - pill3 never pulses.
  - Each pulse lasts 1 cycle.
- Alarm latch/ack: after pill1 fires, alarm_led[0] stays 1 until nxt, then clears. An nxt pulse coincident with a pill fire leaves that bit set.
- prg during RUN (nxt on the same cycle) → SET_ID; alarms 0; pill12And3Duration unchanged; re-entering RUN restarts counts from full durations.
- dur = 1 for all pills → dispense_pulse = 3'b111 on every tick; prescaler wrap verified at TICK_CYCLES-1.
